// File: rtl/bm_cg_eval.sv
// bm_cg_eval: pipelined piecewise-linear cosine evaluator with a run-time loadable coefficient table.
// Define BM_CG_SIN_EN to add the aligned out_sin lane, which has its own copy of the table.

// bm_cg_lane: one evaluation lane, with a coefficient table, a read stage and the interpolation datapath
module bm_cg_lane #(
    parameter int SEG_BITS  = 7,
    parameter int FRAC_BITS = 7,
    parameter int C0_W      = 19,
    parameter int C1_W      = 12
) (
    input  logic                          clock,
    input  logic                          cfg_wr_en,
    input  logic [SEG_BITS-1:0]           cfg_addr,
    input  logic [C0_W+C1_W-1:0]          cfg_wdata,
    input  logic [SEG_BITS+FRAC_BITS-1:0] x,
    input  logic                          neg,
    output logic [C0_W:0]                 res
);
    localparam int TW = C0_W + C1_W;
    localparam int PW = C1_W + FRAC_BITS;

    logic [TW-1:0]        table_mem [2**SEG_BITS];
    logic [TW-1:0]        rd;
    logic [SEG_BITS-1:0]  s1_seg;
    logic [FRAC_BITS-1:0] s1_f, r_f, s2_f;
    logic                 s1_neg, r_neg, s2_neg, s3_neg;
    logic [C0_W-1:0]      s2_c0, s3_c0, e;
    logic [C1_W-1:0]      s2_c1;
    logic [PW-1:0]        s3_prod;

    // Table write, and a synchronous read addressed from S1. The read happens before the write on the same edge.
    always_ff @(posedge clock) begin
        rd <= table_mem[s1_seg];
        if (cfg_wr_en) table_mem[cfg_addr] <= cfg_wdata;
    end

    // Data stages run freely every cycle; the parent tracks which stages hold valid samples.
    always_ff @(posedge clock) begin
        s1_seg  <= x[SEG_BITS+FRAC_BITS-1 -: SEG_BITS];
        s1_f    <= x[FRAC_BITS-1:0];
        s1_neg  <= neg;
        r_f     <= s1_f;
        r_neg   <= s1_neg;
        s2_c0   <= rd[TW-1 -: C0_W];
        s2_c1   <= rd[C1_W-1:0];
        s2_f    <= r_f;
        s2_neg  <= r_neg;
        s3_prod <= PW'(s2_c1) * PW'(s2_f);
        s3_c0   <= s2_c0;
        s3_neg  <= s2_neg;
    end

    // Interpolated magnitude. A valid table has C1 <= C0, so this never wraps.
    always_comb e = s3_c0 - C0_W'(s3_prod >> FRAC_BITS);

    assign res = s3_neg ? -{1'b0, e} : {1'b0, e};
endmodule

module bm_cg_eval #(
    parameter  int SEG_BITS  = 7,
    parameter  int FRAC_BITS = 7,
    parameter  int C0_W      = 19,
    parameter  int C1_W      = 12,
    localparam int PHASE_W   = 2 + SEG_BITS + FRAC_BITS,
    localparam int OUT_W     = C0_W + 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cfg_wr_en,
    input  logic [SEG_BITS-1:0]      cfg_addr,
    input  logic [C0_W+C1_W-1:0]     cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PHASE_W-1:0]       in_phase,
`ifdef BM_CG_SIN_EN
    output logic [OUT_W-1:0]         out_sin,
`endif
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_cos
);
    localparam int IDX_W = SEG_BITS + FRAC_BITS;
`ifdef BM_CG_SIN_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif

    logic                   accept;
    logic [1:0]             q;
    logic [IDX_W-1:0]       p;
    logic [3:0]             vld;
    logic [LANES*OUT_W-1:0] res, out_q;

    assign in_ready = ~cfg_wr_en;
    assign accept   = in_valid & in_ready;
    assign q        = in_phase[PHASE_W-1 -: 2];
    assign p        = in_phase[IDX_W-1:0];

    // Lane 0 is cosine: q1 and q3 use the mirrored phase, and q1 and q2 are negative.
    // Lane 1 is sine: q0 and q2 use the mirrored phase, and q2 and q3 are negative.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bm_cg_lane #(
            .SEG_BITS(SEG_BITS), .FRAC_BITS(FRAC_BITS), .C0_W(C0_W), .C1_W(C1_W)
        ) u_lane (
            .clock(clock),
            .cfg_wr_en(cfg_wr_en),
            .cfg_addr(cfg_addr),
            .cfg_wdata(cfg_wdata),
            .x((q[0] ^ (i == 1)) ? ~p : p),
            .neg((i == 0) ? q[1] ^ q[0] : q[1]),
            .res(res[i*OUT_W +: OUT_W])
        );
    end

    // Stage valids and output registers. Reset drops in-flight samples, and the outputs hold between valid results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld       <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            vld       <= {vld[2:0], accept};
            out_valid <= vld[3];
            if (vld[3]) out_q <= res;
        end
    end

    assign out_cos = out_q[OUT_W-1:0];
`ifdef BM_CG_SIN_EN
    assign out_sin = out_q[2*OUT_W-1 -: OUT_W];
`endif
endmodule

// File: tb/tb_bm_cg_eval.sv
// tb_bm_cg_eval: directed self-checking bench for bm_cg_eval
module tb_bm_cg_eval;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [6:0]  cfg_addr = '0;
    logic [30:0] cfg_wdata = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_phase = '0;
    logic        out_valid;
    logic [19:0] out_cos;
`ifdef BM_CG_SIN_EN
    logic [19:0] out_sin;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0]        ph [8] = '{16'd0, 16'd64, 16'd32768, 16'd16384, 16'd49152, 16'd32832, 16'd64, 16'd0};
    logic signed [19:0] ev [8] = '{20'sd262146, 20'sd262136, -20'sd262146, -20'sd26, 20'sd26, -20'sd262136, 20'sd262136, 20'sd262146};
    logic [15:0]        qp [4] = '{16'd64, 16'd32768, 16'd16384, 16'd49152};
    logic signed [19:0] qe [4] = '{20'sd262136, -20'sd262146, -20'sd26, 20'sd26};

    bm_cg_eval dut (
        .clock(clock),
        .reset_n(reset_n),
        .cfg_wr_en(cfg_wr_en),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_phase(in_phase),
`ifdef BM_CG_SIN_EN
        .out_sin(out_sin),
`endif
        .out_valid(out_valid),
        .out_cos(out_cos)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_entry(input logic [6:0] a, input logic [18:0] c0, input logic [11:0] c1);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_wdata = {c0, c1};
        step();
        cfg_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++; if (out_cos !== 20'd0) begin fails++; $display("FAIL reset_cos got %0d want 0", $signed(out_cos)); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready); end
        reset_n = 1'b1;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
    endtask

    task automatic test_latency();
        write_entry(7'd0, 19'd262146, 12'd20);
        write_entry(7'd127, 19'd3217, 12'd3217);
        in_valid = 1'b1;
        in_phase = 16'd0;
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            step();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_early cycle %0d got %b want 0", n, out_valid); end
        end
        step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lat_valid got %b want 1", out_valid); end
        tests++; if (out_cos !== 20'sd262146) begin fails++; $display("FAIL lat_cos got %0d want 262146", $signed(out_cos)); end
`ifdef BM_CG_SIN_EN
        tests++; if (out_sin !== 20'sd26) begin fails++; $display("FAIL lat_sin got %0d want 26", $signed(out_sin)); end
`endif
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_pulse got %b want 0", out_valid); end
        tests++; if (out_cos !== 20'sd262146) begin fails++; $display("FAIL lat_hold got %0d want 262146", $signed(out_cos)); end
    endtask

    task automatic test_quadrants();
        int n;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_phase = qp[k];
            step();
            in_valid = 1'b0;
            n = 0;
            do begin
                step();
                n++;
            end while (out_valid !== 1'b1 && n < 10);
            tests++; if (n != 4) begin fails++; $display("FAIL quad_latency phase %0d got %0d want 4", qp[k], n); end
            tests++; if (out_cos !== qe[k]) begin fails++; $display("FAIL quad_cos phase %0d got %0d want %0d", qp[k], $signed(out_cos), qe[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            in_phase = ph[c % 8];
            step();
            tests++; if (out_valid !== (c >= 4 && c < 12)) begin fails++; $display("FAIL b2b_valid cycle %0d got %b", c, out_valid); end
            if (out_valid === 1'b1) begin
                if (idx < 8) begin
                    tests++; if (out_cos !== ev[idx]) begin fails++; $display("FAIL b2b_cos idx %0d got %0d want %0d", idx, $signed(out_cos), ev[idx]); end
                end
                idx++;
            end
        end
        in_valid = 1'b0;
        tests++; if (idx != 8) begin fails++; $display("FAIL b2b_count got %0d want 8", idx); end
    endtask

    task automatic test_stall();
        int k;
        int idx;
        k = 0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            cfg_wr_en = (c == 2 || c == 3);
            cfg_addr  = 7'd5;
            cfg_wdata = 31'h1234;
            in_valid  = (k < 6);
            in_phase  = ph[k % 8];
            #1;
            tests++; if (in_ready !== !(c == 2 || c == 3)) begin fails++; $display("FAIL stall_ready cycle %0d got %b", c, in_ready); end
            if (in_valid && !(c == 2 || c == 3)) k++;
            step();
            if (out_valid === 1'b1) begin
                if (idx < 6) begin
                    tests++; if (out_cos !== ev[idx]) begin fails++; $display("FAIL stall_cos idx %0d got %0d want %0d", idx, $signed(out_cos), ev[idx]); end
                end
                idx++;
            end
        end
        cfg_wr_en = 1'b0;
        in_valid  = 1'b0;
        tests++; if (idx != 6) begin fails++; $display("FAIL stall_count got %0d want 6", idx); end
    endtask

    task automatic test_rewrite();
        int idx;
        logic signed [19:0] want;
        in_valid = 1'b1;
        in_phase = 16'd0;
        step();
        in_valid = 1'b0;
        write_entry(7'd0, 19'd100000, 12'd0);
        in_valid = 1'b1;
        in_phase = 16'd0;
        step();
        in_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (out_valid === 1'b1) begin
                want = (idx == 0) ? 20'sd262146 : 20'sd100000;
                tests++; if (out_cos !== want) begin fails++; $display("FAIL rewrite_cos idx %0d got %0d want %0d", idx, $signed(out_cos), want); end
                idx++;
            end
        end
        tests++; if (idx != 2) begin fails++; $display("FAIL rewrite_count got %0d want 2", idx); end
    endtask

    task automatic test_reset_in_flight();
        int n;
        tests++; if (out_cos !== 20'sd100000) begin fails++; $display("FAIL hold_cos got %0d want 100000", $signed(out_cos)); end
        in_valid = 1'b1;
        in_phase = 16'd0;
        step();
        in_phase = 16'd64;
        step();
        in_phase = 16'd32768;
        step();
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_valid got %b want 0", out_valid); end
        tests++; if (out_cos !== 20'd0) begin fails++; $display("FAIL async_cos got %0d want 0", $signed(out_cos)); end
        step();
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL spurious_valid cycle %0d got %b want 0", c, out_valid); end
        end
        in_valid = 1'b1;
        in_phase = 16'd0;
        step();
        in_valid = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (out_valid !== 1'b1 && n < 10);
        tests++; if (n != 4) begin fails++; $display("FAIL retained_latency got %0d want 4", n); end
        tests++; if (out_cos !== 20'sd100000) begin fails++; $display("FAIL retained_cos got %0d want 100000", $signed(out_cos)); end
`ifdef BM_CG_SIN_EN
        tests++; if (out_sin !== 20'sd26) begin fails++; $display("FAIL retained_sin got %0d want 26", $signed(out_sin)); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_quadrants();
        test_back_to_back();
        test_stall();
        test_rewrite();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bm_cg_eval.md
Name: bm_cg_eval

Overview:
- Parametrised, pipelined piecewise-linear cosine evaluator for the Box-Muller noise generator.
- Takes an unsigned full-circle phase and folds it into one quadrant. It then looks up a per-segment coefficient pair {C0, C1} in an internal run-time-loadable table and computes y = C0 - ((C1*f) >> FRAC_BITS).
- Applies the quadrant sign and produces a signed result.
- Replaces fixed per-size coefficient tables: depth and widths are now parameters, and coefficients are written through a config port.

Parameters:
- SEG_BITS, 7: log2 of the number of segments per quadrant; table depth is 2^SEG_BITS.
- FRAC_BITS, 7: phase bits used for interpolation inside a segment.
- C0_W, 19: width of the unsigned segment start value.
- C1_W, 12: width of the unsigned per-segment drop.
- Derived, not overridable:
  - PHASE_W = 2 + SEG_BITS + FRAC_BITS
  - OUT_W = C0_W + 1

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- cfg_wr_en, input, 1: coefficient table write strobe.
- cfg_addr, input, SEG_BITS: table write address.
- cfg_wdata, input, C0_W+C1_W: write data; C0 in the upper C0_W bits, C1 in the lower C1_W bits.
- in_valid, input, 1: phase sample valid.
- in_ready, output, 1: block can accept a sample this cycle.
- in_phase, input, PHASE_W: phase; 0 maps to 0 rad, 2^PHASE_W maps to 2π.
- out_valid, output, 1: result valid, asserted for one cycle per accepted sample.
- out_cos, output, OUT_W: signed two's-complement cosine.

Behaviour:
- Phase decomposition:
  - q = in_phase[PHASE_W-1 -: 2]
  - p = lower SEG_BITS+FRAC_BITS bits
  - Mirrored phase pm = ~p (bitwise complement; a deliberate half-LSB offset).
- Evaluation function E(x): segment s = x[top SEG_BITS], offset f = x[low FRAC_BITS], E = C0[s] - ((C1[s]*f) >> FRAC_BITS).
  - Product width is C1_W+FRAC_BITS; the shift truncates.
  - The subtraction is unsigned and never wraps for a valid table (C1 ≤ C0).
- Quadrant mapping for out_cos:
  - q0: +E(p)
  - q1: -E(pm)
  - q2: -E(p)
  - q3: +E(pm)
  - Result is sign-extended to OUT_W.
- Table:
  - Single-port, synchronous read, 2^SEG_BITS x (C0_W+C1_W).
  - Contents are not reset and are undefined until written.
- Handshake:
  - in_ready = ~cfg_wr_en (combinational). A write always wins the port.
  - A sample is accepted only when in_valid & in_ready.
  - No backpressure on the output; out_valid is a pulse.
- Pipeline, fixed latency 4 cycles from acceptance edge to out_valid:
  - S1: register q, folded index, f; issue table read.
  - S2: capture C0 and C1.
  - S3: register product and C0.
  - S4: subtract, apply sign, register out_cos and out_valid.
- Full throughput: one sample per cycle when cfg_wr_en is low.
- Read/write ordering:
  - A sample whose S1 read occurs before a write edge sees old data; otherwise it sees new data.
  - Writes never corrupt samples already past S2.
- Reset (async assert, sync-safe deassert):
  - All stage valids cleared; out_valid = 0, out_cos = 0.
  - Samples in flight are discarded.
  - Table contents are retained.
- Between valid outputs, out_cos holds its last value.

Optional Feature:
- Macro BM_CG_SIN_EN. When defined, the block adds port out_sin (output, OUT_W), computed in a second lane with the same latency and aligned with out_cos.
- Quadrant mapping for out_sin:
  - q0: +E(pm)
  - q1: +E(p)
  - q2: -E(pm)
  - q3: -E(p)
- The second lane uses a duplicate table copy written by the same cfg port.
- When the macro is undefined, there is no out_sin port and no second table.

Test Plan:
- Write entry 0 = {262146, 20} and entry 127 = {3217, 3217}; in_phase = 0 → out_valid exactly 4 cycles later, out_cos = +262146.
- in_phase = 64 (q0, s0, f64) → out_cos = 262146 - 10 = 262136.
- in_phase = 32768 (q2, p0) → -262146; in_phase = 16384 (q1, pm all-ones: s127, f127) → -(3217 - 3191) = -26; in_phase = 49152 → +26.
- Streaming: 8 back-to-back samples → 8 consecutive out_valid cycles, in order. With cfg_wr_en held 2 cycles mid-stream, in_ready drops for those 2 cycles and no sample is lost or duplicated.
- Rewrite entry 0 to {100000, 0} one cycle after a phase-0 sample is accepted → that sample returns 262146; the next phase-0 sample returns 100000.
- Assert reset_n low with 3 samples in flight → out_valid = 0 and out_cos = 0 immediately. After release, phase 0 returns the still-loaded coefficient value with no spurious out_valid. With BM_CG_SIN_EN defined, phase 0 gives out_sin = +26.
